// File: rtl/add40_arbiter_pkg.sv
// Shared constants and types for the two-requester 40-bit adder arbiter.
package add40_arbiter_pkg;

    localparam int OP_W  = 40;  // operand / sum width
    localparam int CNT_W = 16;  // per-requester grant counter width

    // Output slot occupancy.
    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    // Operands selected by the grant mux.
    typedef struct packed {
        logic [OP_W-1:0] a;
        logic [OP_W-1:0] b;
        logic            cin;
    } add_op_t;

endpackage

// File: rtl/add40_core.sv
// Purely combinational 40-bit adder with carry-in and carry-out.
module add40_core
    import add40_arbiter_pkg::*;
(
    input  logic [OP_W-1:0] a_i,
    input  logic [OP_W-1:0] b_i,
    input  logic            cin_i,
    output logic [OP_W-1:0] s_o,
    output logic            cout_o
);

    // Widen to 41 bits so the top bit is the carry out of bit 39.
    assign {cout_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {{OP_W{1'b0}}, cin_i};

endmodule

// File: rtl/add40_arbiter.sv
// Two requesters share one 40-bit adder; a single-entry result slot
// holds the registered sum until the consumer takes it.
module add40_arbiter
    import add40_arbiter_pkg::*;
#(
    parameter int RR = 1  // 1: round-robin, 0: requester 0 always wins
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             r0_valid,
    output logic             r0_ready,
    input  logic [OP_W-1:0]  r0_A,
    input  logic [OP_W-1:0]  r0_B,
    input  logic             r0_Cin,
    input  logic             r1_valid,
    output logic             r1_ready,
    input  logic [OP_W-1:0]  r1_A,
    input  logic [OP_W-1:0]  r1_B,
    input  logic             r1_Cin,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [OP_W-1:0]  res_S,
    output logic             res_Cout,
    output logic             res_id,
    output logic [CNT_W-1:0] gnt_cnt0,
    output logic [CNT_W-1:0] gnt_cnt1
);

    slot_state_e      state_q;
    logic             ptr_q;      // requester favoured when both are valid
    logic [OP_W-1:0]  s_q;
    logic             cout_q;
    logic             id_q;
    logic [CNT_W-1:0] cnt0_q, cnt0_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;

    logic             win_id;
    logic             slot_free;
    logic             accept;
    add_op_t          op_sel;
    logic [OP_W-1:0]  sum;
    logic             sum_cout;

    // Grant winner: a lone requester wins; on contention the pointer or requester 0.
    always_comb begin
        win_id = 1'b0;
        if (r0_valid && r1_valid) begin
            win_id = (RR != 0) ? ptr_q : 1'b0;
        end else if (r1_valid) begin
            win_id = 1'b1;
        end
    end

    // The slot can take a new result if empty or if it drains this same cycle.
    assign slot_free = (state_q == SLOT_EMPTY) || res_ready;
    assign accept    = !rst && slot_free && (r0_valid || r1_valid);
    assign r0_ready  = accept && !win_id;
    assign r1_ready  = accept && win_id;

    assign op_sel = win_id ? '{a: r1_A, b: r1_B, cin: r1_Cin}
                           : '{a: r0_A, b: r0_B, cin: r0_Cin};

    add40_core u_core (
        .a_i   (op_sel.a),
        .b_i   (op_sel.b),
        .cin_i (op_sel.cin),
        .s_o   (sum),
        .cout_o(sum_cout)
    );

    assign cnt0_d = cnt0_q + CNT_W'(1);
    assign cnt1_d = cnt1_q + CNT_W'(1);

    // Slot FSM, result register, priority pointer and grant counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SLOT_EMPTY;
            ptr_q   <= 1'b0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            id_q    <= 1'b0;
            cnt0_q  <= '0;
            cnt1_q  <= '0;
        end else begin
            case (state_q)
                SLOT_EMPTY: if (accept) state_q <= SLOT_FULL;
                SLOT_FULL:  if (res_ready && !accept) state_q <= SLOT_EMPTY;
                default:    state_q <= SLOT_EMPTY;
            endcase
            if (accept) begin
                s_q    <= sum;
                cout_q <= sum_cout;
                id_q   <= win_id;
                ptr_q  <= ~win_id;  // the loser gets priority next time
            end
            if (r0_ready) cnt0_q <= cnt0_d;
            if (r1_ready) cnt1_q <= cnt1_d;
        end
    end

    assign res_valid = (state_q == SLOT_FULL);
    assign res_S     = s_q;
    assign res_Cout  = cout_q;
    assign res_id    = id_q;
    assign gnt_cnt0  = cnt0_q;
    assign gnt_cnt1  = cnt1_q;

endmodule

// File: tb/tb_add40_arbiter.sv
// Directed bench for add40_arbiter with a result scoreboard.
module tb_add40_arbiter;
    import add40_arbiter_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic             r0_valid, r1_valid, r0_Cin, r1_Cin, res_ready;
    logic [OP_W-1:0]  r0_A, r0_B, r1_A, r1_B;
    // round-robin instance
    logic             r0_ready, r1_ready, res_valid, res_Cout, res_id;
    logic [OP_W-1:0]  res_S;
    logic [CNT_W-1:0] gnt_cnt0, gnt_cnt1;
    // fixed-priority instance
    logic             f_r0_ready, f_r1_ready, f_res_valid, f_res_Cout, f_res_id;
    logic [OP_W-1:0]  f_res_S;
    logic [CNT_W-1:0] f_gnt_cnt0, f_gnt_cnt1;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [OP_W-1:0] s;
        logic            cout;
        logic            id;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    add40_arbiter #(.RR(1)) dut (
        .clk(clk), .rst(rst),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_A(r0_A), .r0_B(r0_B), .r0_Cin(r0_Cin),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_A(r1_A), .r1_B(r1_B), .r1_Cin(r1_Cin),
        .res_valid(res_valid), .res_ready(res_ready), .res_S(res_S), .res_Cout(res_Cout),
        .res_id(res_id), .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
    );

    add40_arbiter #(.RR(0)) dut_fp (
        .clk(clk), .rst(rst),
        .r0_valid(r0_valid), .r0_ready(f_r0_ready), .r0_A(r0_A), .r0_B(r0_B), .r0_Cin(r0_Cin),
        .r1_valid(r1_valid), .r1_ready(f_r1_ready), .r1_A(r1_A), .r1_B(r1_B), .r1_Cin(r1_Cin),
        .res_valid(f_res_valid), .res_ready(res_ready), .res_S(f_res_S), .res_Cout(f_res_Cout),
        .res_id(f_res_id), .gnt_cnt0(f_gnt_cnt0), .gnt_cnt1(f_gnt_cnt1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b,
                                   input logic cin, input logic id);
        logic [OP_W:0] t;
        t = {1'b0, a} + {1'b0, b} + {{OP_W{1'b0}}, cin};
        model = '{s: t[OP_W-1:0], cout: t[OP_W], id: id};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    // Scoreboard: pop on result transfer, push on request transfer.
    always @(negedge clk) begin
        if (rst) begin
            sb_q.delete();
        end else begin
            if (res_valid && res_ready) begin
                chk("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
                if (sb_q.size() != 0) begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("sb_S", 64'(res_S), 64'(e.s));
                    chk("sb_Cout", 64'(res_Cout), 64'(e.cout));
                    chk("sb_id", 64'(res_id), 64'(e.id));
                end
            end
            if (r0_valid && r0_ready) sb_q.push_back(model(r0_A, r0_B, r0_Cin, 1'b0));
            if (r1_valid && r1_ready) sb_q.push_back(model(r1_A, r1_B, r1_Cin, 1'b1));
        end
    end

    initial begin
        exp_t held;
        exp_t refill;
        int   waited;

        rst = 1'b1; r0_valid = 1'b1; r1_valid = 1'b1; res_ready = 1'b1;
        r0_A = '0; r0_B = '0; r0_Cin = 1'b0; r1_A = '0; r1_B = '0; r1_Cin = 1'b0;

        // Reset state, requests masked while in reset
        smp();
        chk("rst_res_valid", 64'(res_valid), 64'd0);
        chk("rst_res_S", 64'(res_S), 64'd0);
        chk("rst_res_Cout", 64'(res_Cout), 64'd0);
        chk("rst_res_id", 64'(res_id), 64'd0);
        chk("rst_gnt0", 64'(gnt_cnt0), 64'd0);
        chk("rst_gnt1", 64'(gnt_cnt1), 64'd0);
        chk("rst_r0_ready", 64'(r0_ready), 64'd0);
        chk("rst_r1_ready", 64'(r1_ready), 64'd0);
        cyc();
        rst = 1'b0; r0_valid = 1'b0; r1_valid = 1'b0;

        // Single request
        cyc();
        r0_valid = 1'b1; r0_A = 40'h00000000FF; r0_B = 40'h0000000001; r0_Cin = 1'b0;
        smp();
        chk("single_r0_ready", 64'(r0_ready), 64'd1);
        chk("single_r1_ready", 64'(r1_ready), 64'd0);
        cyc();
        r0_valid = 1'b0;
        smp();
        chk("single_valid", 64'(res_valid), 64'd1);
        chk("single_S", 64'(res_S), 64'h0000000100);
        chk("single_Cout", 64'(res_Cout), 64'd0);
        chk("single_id", 64'(res_id), 64'd0);
        chk("single_gnt0", 64'(gnt_cnt0), 64'd1);

        // Overflow of bit 39
        cyc();
        r0_valid = 1'b1; r0_A = 40'hFFFFFFFFFF; r0_B = 40'h0; r0_Cin = 1'b1;
        cyc();
        r0_valid = 1'b0;
        smp();
        chk("ovf_S", 64'(res_S), 64'd0);
        chk("ovf_Cout", 64'(res_Cout), 64'd1);

        // Contention for six cycles from a fresh reset
        pulse_reset();
        r0_valid = 1'b1; r1_valid = 1'b1; res_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            r0_A = 40'(k * 16 + 1); r0_B = 40'h10; r0_Cin = k[0];
            r1_A = 40'(k * 256 + 7); r1_B = 40'hFFFFFFFFF0; r1_Cin = 1'b1;
            smp();
            chk($sformatf("rr_r0_ready%0d", k), 64'(r0_ready), 64'(k % 2 == 0));
            chk($sformatf("rr_r1_ready%0d", k), 64'(r1_ready), 64'(k % 2 == 1));
            chk($sformatf("fp_r0_ready%0d", k), 64'(f_r0_ready), 64'd1);
            chk($sformatf("fp_r1_ready%0d", k), 64'(f_r1_ready), 64'd0);
            if (k > 0) begin
                chk($sformatf("rr_id%0d", k - 1), 64'(res_id), 64'((k - 1) % 2));
                chk($sformatf("fp_id%0d", k - 1), 64'(f_res_id), 64'd0);
            end
            cyc();
        end
        r0_valid = 1'b0; r1_valid = 1'b0;
        smp();
        chk("rr_id5", 64'(res_id), 64'd1);
        chk("fp_id5", 64'(f_res_id), 64'd0);
        chk("rr_gnt0", 64'(gnt_cnt0), 64'd3);
        chk("rr_gnt1", 64'(gnt_cnt1), 64'd3);
        chk("fp_gnt0", 64'(f_gnt_cnt0), 64'd6);
        chk("fp_gnt1", 64'(f_gnt_cnt1), 64'd0);

        // Backpressure: one accept, then hold while res_ready is low
        cyc();
        res_ready = 1'b0; r0_valid = 1'b1; r1_valid = 1'b1;
        r0_A = 40'h123456789A; r0_B = 40'h1111111111; r0_Cin = 1'b1;
        r1_A = 40'h8000000000; r1_B = 40'h8000000001; r1_Cin = 1'b0;
        held   = model(r0_A, r0_B, r0_Cin, 1'b0);
        refill = model(r1_A, r1_B, r1_Cin, 1'b1);
        smp();
        chk("bp_r0_ready", 64'(r0_ready), 64'd1);
        chk("bp_r1_ready", 64'(r1_ready), 64'd0);
        cyc();
        for (int i = 0; i < 4; i++) begin
            smp();
            chk($sformatf("bp_hold_r0_ready%0d", i), 64'(r0_ready), 64'd0);
            chk($sformatf("bp_hold_r1_ready%0d", i), 64'(r1_ready), 64'd0);
            chk($sformatf("bp_hold_valid%0d", i), 64'(res_valid), 64'd1);
            chk($sformatf("bp_hold_S%0d", i), 64'(res_S), 64'(held.s));
            chk($sformatf("bp_hold_id%0d", i), 64'(res_id), 64'd0);
            cyc();
        end
        res_ready = 1'b1;
        smp();
        chk("bp_refill_r1_ready", 64'(r1_ready), 64'd1);
        chk("bp_refill_r0_ready", 64'(r0_ready), 64'd0);
        cyc();
        r0_valid = 1'b0; r1_valid = 1'b0;
        smp();
        chk("bp_refill_valid", 64'(res_valid), 64'd1);
        chk("bp_refill_S", 64'(res_S), 64'(refill.s));
        chk("bp_refill_Cout", 64'(res_Cout), 64'(refill.cout));
        chk("bp_refill_id", 64'(res_id), 64'd1);
        chk("bp_gnt0", 64'(gnt_cnt0), 64'd4);
        chk("bp_gnt1", 64'(gnt_cnt1), 64'd4);

        // Reset while an r1 result is held
        cyc();
        res_ready = 1'b0; r1_valid = 1'b1; r1_A = 40'h0000000ABC; r1_B = 40'h5; r1_Cin = 1'b0;
        smp();
        chk("rm_r1_ready", 64'(r1_ready), 64'd1);
        cyc();
        r1_valid = 1'b0;
        smp();
        chk("rm_pre_valid", 64'(res_valid), 64'd1);
        #1;
        rst = 1'b1;
        r0_valid = 1'b1; r1_valid = 1'b1;
        #1;
        chk("rm_valid", 64'(res_valid), 64'd0);
        chk("rm_S", 64'(res_S), 64'd0);
        chk("rm_gnt0", 64'(gnt_cnt0), 64'd0);
        chk("rm_gnt1", 64'(gnt_cnt1), 64'd0);
        chk("rm_r0_ready", 64'(r0_ready), 64'd0);
        chk("rm_r1_ready", 64'(r1_ready), 64'd0);
        smp();
        cyc();
        rst = 1'b0; res_ready = 1'b1;
        r0_A = 40'h0000000010; r0_B = 40'h20; r0_Cin = 1'b0;
        smp();
        chk("rm_first_r0_ready", 64'(r0_ready), 64'd1);
        chk("rm_first_r1_ready", 64'(r1_ready), 64'd0);
        cyc();
        r0_valid = 1'b0; r1_valid = 1'b0;
        smp();
        chk("rm_first_id", 64'(res_id), 64'd0);
        chk("rm_first_S", 64'(res_S), 64'h30);

        // Counter wrap after 65536 accepts from r0
        pulse_reset();
        r0_valid = 1'b1; r1_valid = 1'b0; res_ready = 1'b1;
        r0_A = 40'h00000ABCDE; r0_B = 40'h1; r0_Cin = 1'b0;
        repeat (65535) @(posedge clk);
        smp();
        chk("wrap_gnt0_max", 64'(gnt_cnt0), 64'hFFFF);
        @(posedge clk);
        #1;
        r0_valid = 1'b0;
        smp();
        chk("wrap_gnt0", 64'(gnt_cnt0), 64'd0);
        chk("wrap_gnt1", 64'(gnt_cnt1), 64'd0);
        chk("wrap_fp_gnt0", 64'(f_gnt_cnt0), 64'd0);

        // Pointer returns to requester 0 after reset (last grant was r0)
        cyc();
        rst = 1'b1; r0_valid = 1'b1; r1_valid = 1'b1;
        smp();
        cyc();
        rst = 1'b0;
        smp();
        chk("ptr_rst_r0_ready", 64'(r0_ready), 64'd1);
        chk("ptr_rst_r1_ready", 64'(r1_ready), 64'd0);
        cyc();
        r0_valid = 1'b0; r1_valid = 1'b0;

        // Drain whatever the scoreboard still expects
        waited = 0;
        while (sb_q.size() != 0 && waited < 10) begin
            smp();
            waited++;
        end
        chk("drain_empty", 64'(sb_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
